i2s_frame_tx: RTL and testbench

Parametrised I2S/TDM audio transmitter for the sound box output path. It takes whole audio frames (all channels) over a valid/ready stream, buffers them in a small FIFO, and divides `audio_mclk` down to produce `audio_bclk`, `audio_lrck` and `audio_data`. It drives the codec pins directly from registers, generalising the two-channel output to N channels, configurable sample and slot widths, and TDM framing. It also detects underruns.

---
 rtl/audio_pkg.sv | 26 ++
 rtl/audio_frame_fifo.sv | 64 ++++++
 rtl/i2s_frame_tx.sv | 165 ++++++++++++++++
 tb/tb_i2s_frame_tx.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: default parameters, frame/level width helpers and the
// transmitter state enum.
package audio_pkg;

  localparam int unsigned DefSampleW   = 16;
  localparam int unsigned DefSlotW     = 32;
  localparam int unsigned DefChannels  = 2;
  localparam int unsigned DefMclkDiv   = 4;
  localparam int unsigned DefFifoDepth = 4;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } tx_state_e;

  function automatic int unsigned frame_bits(input int unsigned channels,
                                             input int unsigned slot_w);
    return channels * slot_w;
  endfunction

  // Level counters need one extra bit to represent "full".
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with registered level and ready; head word is shown on rd_data_o.
// Shared between the audio transmit and receive paths.
module audio_frame_fifo import audio_pkg::*; #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = DefFifoDepth
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_i,
  input  logic [Width-1:0]          wr_data_i,
  input  logic                      rd_i,
  output logic [Width-1:0]          rd_data_o,
  output logic                      empty_o,
  output logic                      ready_o,
  output logic [level_w(Depth)-1:0] level_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned LevelW = level_w(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] level_q, level_d;
  logic              ready_q, ready_d;
  logic              wr_en, rd_en;

  // A pop while full frees space only once ready_q has been re-registered.
  assign wr_en = wr_i & ready_q;
  assign rd_en = rd_i & (level_q != '0);

  always_comb begin
    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ready_d = (level_d != LevelW'(Depth));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (level_q == '0);
  assign ready_o   = ready_q;
  assign level_o   = level_q;

endmodule

// File: rtl/i2s_frame_tx.sv
// I2S/TDM frame transmitter: buffers whole frames and serialises them with a one-bit delay.
// Define I2S_FRAME_TX_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module i2s_frame_tx import audio_pkg::*; #(
  parameter int unsigned SAMPLE_W   = DefSampleW,
  parameter int unsigned SLOT_W     = DefSlotW,
  parameter int unsigned CHANNELS   = DefChannels,
  parameter int unsigned MCLK_DIV   = DefMclkDiv,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic                               audio_mclk,
  input  logic                               audio_rst_n,
  input  logic                               en,
  input  logic                               s_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0]       s_data,
  output logic                               s_ready,
  output logic                               audio_bclk,
  output logic                               audio_lrck,
  output logic                               audio_data,
  output logic                               underrun,
`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
  output logic [level_w(FIFO_DEPTH)-1:0]     fifo_level,
  output logic [15:0]                        underrun_cnt
`else
  output logic [level_w(FIFO_DEPTH)-1:0]     fifo_level
`endif
);

  localparam int unsigned FrameBits = frame_bits(CHANNELS, SLOT_W);
  localparam int unsigned InW       = CHANNELS * SAMPLE_W;
  localparam int unsigned BitW      = $clog2(FrameBits);
  localparam int unsigned DivW      = $clog2(MCLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(MCLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(MCLK_DIV / 2);
  localparam logic [BitW-1:0] BitLast = BitW'(FrameBits - 1);
  localparam logic [BitW-1:0] SlotEnd = BitW'(SLOT_W);
  localparam bit              I2sMode = (CHANNELS == 2);

  tx_state_e            state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [FrameBits-1:0] shift_q, shift_d;
  logic                 bclk_q, bclk_d;
  logic                 lrck_q, lrck_d;
  logic                 data_q, data_d;
  logic                 underrun_q, underrun_d;
  logic                 load, pop, run_d;
  logic                 fifo_empty;
  logic [InW-1:0]       fifo_head;
  logic [FrameBits-1:0] frame_word;

  audio_frame_fifo #(
    .Width (InW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (audio_mclk),
    .rst_ni    (audio_rst_n),
    .wr_i      (s_valid),
    .wr_data_i (s_data),
    .rd_i      (pop),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .ready_o   (s_ready),
    .level_o   (fifo_level)
  );

  // Left-justify each sample in its slot; an empty FIFO yields a silent frame.
  always_comb begin
    frame_word = '0;
    if (!fifo_empty) begin
      for (int ch = 0; ch < int'(CHANNELS); ch++) begin
        frame_word[FrameBits-1-ch*SLOT_W -: SAMPLE_W] = fifo_head[InW-1-ch*SAMPLE_W -: SAMPLE_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        div_d   = '0;
        bit_d   = '0;
        shift_d = '0;
        data_d  = 1'b0;
        if (en) state_d = StRun;
      end
      StRun: begin
        if (!en) begin
          state_d = StIdle;
          div_d   = '0;
          bit_d   = '0;
          shift_d = '0;
          data_d  = 1'b0;
        end else if (div_q == DivLast) begin
          div_d = '0;
          bit_d = (bit_q == BitLast) ? '0 : bit_q + 1'b1;
          // Crossing into frame bit 1: fetch the next frame and present its MSB.
          if (bit_q == '0) begin
            load    = 1'b1;
            data_d  = frame_word[FrameBits-1];
            shift_d = {frame_word[FrameBits-2:0], 1'b0};
          end else begin
            data_d  = shift_q[FrameBits-1];
            shift_d = {shift_q[FrameBits-2:0], 1'b0};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    pop        = load & ~fifo_empty;
    underrun_d = load & fifo_empty;
    run_d      = (state_d == StRun);
    bclk_d     = run_d & (div_d >= DivHalf);
    lrck_d     = run_d & (I2sMode ? (bit_d >= SlotEnd) : (bit_d == '0));
  end

  always_ff @(posedge audio_mclk or negedge audio_rst_n) begin
    if (!audio_rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end

  assign audio_bclk = bclk_q;
  assign audio_lrck = lrck_q;
  assign audio_data = data_q;
  assign underrun   = underrun_q;

`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge audio_mclk or negedge audio_rst_n) begin
    if (!audio_rst_n) begin
      ucnt_q <= '0;
    end else if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Directed bench for i2s_frame_tx: default I2S instance plus an 8-channel TDM instance.
module tb_i2s_frame_tx;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, s_valid, s_ready, bclk, lrck, data, underrun;
  logic [31:0]  s_data;
  logic [2:0]   fifo_level;
  logic         t_en, t_valid, t_ready, t_bclk, t_lrck, t_data, t_underrun;
  logic [127:0] t_s_data;
  logic [2:0]   t_level;
`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
  logic [15:0]  ucnt, t_ucnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2s_frame_tx u_dut (
    .audio_mclk  (clk),
    .audio_rst_n (rst_n),
    .en          (en),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .audio_bclk  (bclk),
    .audio_lrck  (lrck),
    .audio_data  (data),
    .underrun    (underrun),
`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
    .fifo_level  (fifo_level),
    .underrun_cnt(ucnt)
`else
    .fifo_level  (fifo_level)
`endif
  );

  i2s_frame_tx #(
    .SAMPLE_W (16),
    .SLOT_W   (16),
    .CHANNELS (8)
  ) u_tdm (
    .audio_mclk  (clk),
    .audio_rst_n (rst_n),
    .en          (t_en),
    .s_valid     (t_valid),
    .s_data      (t_s_data),
    .s_ready     (t_ready),
    .audio_bclk  (t_bclk),
    .audio_lrck  (t_lrck),
    .audio_data  (t_data),
    .underrun    (t_underrun),
`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
    .fifo_level  (t_level),
    .underrun_cnt(t_ucnt)
`else
    .fifo_level  (t_level)
`endif
  );

  // Two-channel frame word: each 16-bit sample left-justified in a 32-bit slot.
  function automatic logic [127:0] f_i2s(input logic [31:0] d);
    return {64'h0, d[31:16], 16'h0, d[15:0], 16'h0};
  endfunction

  // Expected per-bit data: bit 0 carries the previous LSB, bit n carries F[nbits-n].
  function automatic logic [127:0] exp_bits(input logic [127:0] f, input int nbits,
                                            input logic prev_lsb);
    logic [127:0] e;
    e = '0;
    e[0] = prev_lsb;
    for (int b = 1; b < nbits; b++) e[b] = f[nbits-b];
    return e;
  endfunction

  task automatic push(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Records one frame starting at frame bit 0; returns at bit 0 of the following frame.
  task automatic capture(input bit tdm, input int nbits, output logic [127:0] dat,
                         output logic [127:0] lr, output int edge_err, output int under_n,
                         output int under_pos, output int lr_hi_n);
    logic b_v, l_v, d_v, u_v;
    dat = '0; lr = '0; edge_err = 0; under_n = 0; under_pos = -1; lr_hi_n = 0;
    for (int c = 0; c < nbits * 4; c++) begin
      b_v = tdm ? t_bclk : bclk;
      l_v = tdm ? t_lrck : lrck;
      d_v = tdm ? t_data : data;
      u_v = tdm ? t_underrun : underrun;
      if (b_v !== ((c % 4) >= 2)) edge_err++;
      if (c % 4 == 0) begin
        dat[c/4] = d_v;
        lr[c/4]  = l_v;
      end else if (d_v !== dat[c/4] || l_v !== lr[c/4]) begin
        edge_err++;
      end
      if (u_v === 1'b1) begin
        under_n++;
        under_pos = c;
      end
      if (l_v === 1'b1) lr_hi_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, bclk, lrck, data, underrun, fifo_level} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {s_ready, bclk, lrck, data, underrun, fifo_level});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_release got=%b exp=0", s_ready);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL reset_ready_after got=%b/%0d exp=1/0", s_ready, fifo_level);
    end
  endtask

  task automatic test_basic();
    logic [127:0] dat, lr, ex;
    int ee, un, up, lh;
    logic [15:0] w1, w2;
    en = 1'b0;
    push(32'hA5F0_0F0F);
    checks++;
    if (fifo_level !== 3'd1) begin
      failures++;
      $display("FAIL basic_level got=%0d exp=1", fifo_level);
    end
    en = 1'b1;
    @(negedge clk);
    capture(1'b0, 64, dat, lr, ee, un, up, lh);
    en = 1'b0;
    for (int b = 1; b <= 16; b++) begin
      w1[16-b] = dat[b];
      w2[16-b] = dat[32+b];
    end
    ex = exp_bits(f_i2s(32'hA5F0_0F0F), 64, 1'b0);
    checks++;
    if (w1 !== 16'hA5F0) begin
      failures++;
      $display("FAIL basic_ch0 got=%h exp=a5f0", w1);
    end
    checks++;
    if (w2 !== 16'h0F0F) begin
      failures++;
      $display("FAIL basic_ch1 got=%h exp=0f0f", w2);
    end
    checks++;
    if (dat[63:0] !== ex[63:0]) begin
      failures++;
      $display("FAIL basic_data got=%h exp=%h", dat[63:0], ex[63:0]);
    end
    checks++;
    if (lr[63:0] !== 64'hFFFF_FFFF_0000_0000 || lh != 128) begin
      failures++;
      $display("FAIL basic_lrck got=%h/%0d exp=ffffffff00000000/128", lr[63:0], lh);
    end
    checks++;
    if (ee != 0 || un != 0) begin
      failures++;
      $display("FAIL basic_bclk_underrun got=%0d/%0d exp=0/0", ee, un);
    end
    @(negedge clk);
    checks++;
    if ({bclk, lrck, data, underrun} !== 4'b0000) begin
      failures++;
      $display("FAIL basic_idle got=%b exp=0000", {bclk, lrck, data, underrun});
    end
  endtask

  task automatic test_underrun();
    logic [127:0] dat, lr;
    int ee, un, up, lh;
    en = 1'b1;
    @(negedge clk);
    capture(1'b0, 64, dat, lr, ee, un, up, lh);
    en = 1'b0;
    checks++;
    if (un != 1 || up != 4) begin
      failures++;
      $display("FAIL underrun_pulse got=%0d@%0d exp=1@4", un, up);
    end
    checks++;
    if (dat[63:0] !== 64'h0) begin
      failures++;
      $display("FAIL underrun_silent got=%h exp=0", dat[63:0]);
    end
    checks++;
    if (lr[63:0] !== 64'hFFFF_FFFF_0000_0000 || ee != 0) begin
      failures++;
      $display("FAIL underrun_cadence got=%h/%0d exp=ffffffff00000000/0", lr[63:0], ee);
    end
    @(negedge clk);
`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
    checks++;
    if (ucnt !== 16'd1) begin
      failures++;
      $display("FAIL underrun_cnt got=%0d exp=1", ucnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] bp [5];
    logic [127:0] dat, lr, ex;
    int ee, un, up, lh, idx, c;
    logic rdy;
    bp[0] = 32'h8001_7FFE; bp[1] = 32'h1234_5678; bp[2] = 32'hFFFF_0000;
    bp[3] = 32'h0001_8000; bp[4] = 32'hC3C3_3C3C;
    en = 1'b0;
    idx = 0;
    s_valid = 1'b1;
    s_data = bp[0];
    repeat (4) begin
      rdy = s_ready;
      @(negedge clk);
      if (rdy && idx < 4) begin
        idx++;
        s_data = bp[idx];
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (idx != 4 || s_ready !== 1'b0 || fifo_level !== 3'd4) begin
      failures++;
      $display("FAIL bp_full got=%0d/%b/%0d exp=4/0/4", idx, s_ready, fifo_level);
    end
    en = 1'b1;
    @(negedge clk);
    c = 0;
    while (s_ready !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c != 4 || fifo_level !== 3'd3) begin
      failures++;
      $display("FAIL bp_ready_after_pop got=%0d/%0d exp=4/3", c, fifo_level);
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd4) begin
      failures++;
      $display("FAIL bp_fifth_accepted got=%0d exp=4", fifo_level);
    end
    repeat (256 - c - 1) @(negedge clk);
    for (int k = 1; k < 5; k++) begin
      capture(1'b0, 64, dat, lr, ee, un, up, lh);
      ex = exp_bits(f_i2s(bp[k]), 64, 1'b0);
      checks++;
      if (dat[63:0] !== ex[63:0] || un != 0) begin
        failures++;
        $display("FAIL bp_frame%0d got=%h/%0d exp=%h/0", k, dat[63:0], un, ex[63:0]);
      end
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_drained got=%0d/%b exp=0/1", fifo_level, s_ready);
    end
  endtask

  task automatic test_tdm();
    logic [127:0] dat, lr, ex;
    int ee, un, up, lh;
    for (int k = 0; k < 8; k++) t_s_data[(7-k)*16 +: 16] = {4'(k), 12'h5A3};
    t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    t_en = 1'b1;
    @(negedge clk);
    capture(1'b1, 128, dat, lr, ee, un, up, lh);
    ex = exp_bits(t_s_data, 128, 1'b0);
    checks++;
    if (dat !== ex || un != 0) begin
      failures++;
      $display("FAIL tdm_data got=%h/%0d exp=%h/0", dat, un, ex);
    end
    checks++;
    if (lr !== 128'h1 || lh != 4 || ee != 0) begin
      failures++;
      $display("FAIL tdm_lrck got=%h/%0d/%0d exp=1/4/0", lr, lh, ee);
    end
    capture(1'b1, 128, dat, lr, ee, un, up, lh);
    t_en = 1'b0;
    checks++;
    if (dat[0] !== 1'b1) begin
      failures++;
      $display("FAIL tdm_ch7_lsb got=%b exp=1", dat[0]);
    end
    checks++;
    if (dat !== 128'h1 || lr !== 128'h1 || un != 1 || up != 4) begin
      failures++;
      $display("FAIL tdm_second_frame got=%h/%h/%0d@%0d exp=1/1/1@4", dat, lr, un, up);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [127:0] dat, lr;
    int ee, un, up, lh;
    en = 1'b0;
    push(32'h1111_2222);
    push(32'h3333_4444);
    en = 1'b1;
    @(negedge clk);
    repeat (82) @(negedge clk);
    checks++;
    if (bclk !== 1'b1 || fifo_level !== 3'd1) begin
      failures++;
      $display("FAIL rstmid_before got=%b/%0d exp=1/1", bclk, fifo_level);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, bclk, lrck, data, underrun, fifo_level} !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b exp=00000000",
               {s_ready, bclk, lrck, data, underrun, fifo_level});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    capture(1'b0, 64, dat, lr, ee, un, up, lh);
    en = 1'b0;
    checks++;
    if (lr[63:0] !== 64'hFFFF_FFFF_0000_0000 || ee != 0 || dat[63:0] !== 64'h0 ||
        un != 1 || up != 4) begin
      failures++;
      $display("FAIL rstmid_restart got=%h/%0d/%h/%0d@%0d exp=ffffffff00000000/0/0/1@4",
               lr[63:0], ee, dat[63:0], un, up);
    end
    @(negedge clk);
`ifdef I2S_FRAME_TX_UNDERRUN_CNT_EN
    checks++;
    if (ucnt !== 16'd1) begin
      failures++;
      $display("FAIL rstmid_cnt got=%0d exp=1", ucnt);
    end
`endif
  endtask

  task automatic test_enable_drop();
    logic [127:0] dat, lr, ex;
    int ee, un, up, lh;
    en = 1'b0;
    push(32'h3C4E_1234);
    push(32'hFFFF_8000);
    en = 1'b1;
    @(negedge clk);
    repeat (42) @(negedge clk);
    checks++;
    if (data !== 1'b1 || bclk !== 1'b1 || fifo_level !== 3'd1) begin
      failures++;
      $display("FAIL drop_before got=%b/%b/%0d exp=1/1/1", data, bclk, fifo_level);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({bclk, lrck, data, underrun} !== 4'b0000 || fifo_level !== 3'd1) begin
      failures++;
      $display("FAIL drop_idle got=%b/%0d exp=0000/1", {bclk, lrck, data, underrun}, fifo_level);
    end
    repeat (5) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    capture(1'b0, 64, dat, lr, ee, un, up, lh);
    en = 1'b0;
    ex = exp_bits(f_i2s(32'hFFFF_8000), 64, 1'b0);
    checks++;
    if (dat[63:0] !== ex[63:0] || lr[63:0] !== 64'hFFFF_FFFF_0000_0000 || un != 0) begin
      failures++;
      $display("FAIL drop_resume got=%h/%h/%0d exp=%h/ffffffff00000000/0",
               dat[63:0], lr[63:0], un, ex[63:0]);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; s_valid = 1'b0; s_data = '0;
    t_en = 1'b0; t_valid = 1'b0; t_s_data = '0;
    test_reset();
    test_basic();
    test_underrun();
    test_backpressure();
    test_tdm();
    test_reset_mid();
    test_enable_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
